ram64x18: RTL and testbench

RAM64X18 -- requirements
Module: ram64x18

---
 rtl/ram64x18.sv | 146 ++++++++++++++
 tb/tb_ram64x18.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/ram64x18.sv
// 64x18 RAM with two independent registered-address read ports (A, B) and one write port (C).
// Optional macro RAM64X18_RESET_ARRAY_EN: aresetn also clears the whole array.
module ram64x18 (
    input  logic        clock,
    input  logic        aresetn,
    input  logic [9:0]  a_addr,
    input  logic [1:0]  a_blk,
    input  logic        a_addr_en,
    input  logic        a_dout_en,
    input  logic        a_dout_lat,
    input  logic [2:0]  a_width,
    output logic [17:0] a_dout,
    input  logic [9:0]  b_addr,
    input  logic [1:0]  b_blk,
    input  logic        b_addr_en,
    input  logic        b_dout_en,
    input  logic        b_dout_lat,
    input  logic [2:0]  b_width,
    output logic [17:0] b_dout,
    input  logic [9:0]  c_addr,
    input  logic [17:0] c_din,
    input  logic        c_wen,
    input  logic [1:0]  c_blk,
    input  logic [2:0]  c_width,
    output logic        busy
);

    localparam int unsigned DATA_W = 18;
    localparam int unsigned HALF_W = 9;
    localparam int unsigned DEPTH  = 64;
    localparam int unsigned WORD_W = 6;
    localparam logic [2:0]  WIDTH_X9 = 3'b011;
    localparam logic [1:0]  BLK_ON   = 2'b11;

    // Registered read-port context: word index, half select, width code, block select.
    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic              half;
        logic [2:0]        width;
        logic [1:0]        blk;
    } rd_ctx_t;

    logic [DATA_W-1:0] mem [DEPTH];

    rd_ctx_t           a_q;
    rd_ctx_t           b_q;
    logic [DATA_W-1:0] a_flow;
    logic [DATA_W-1:0] b_flow;
    logic [DATA_W-1:0] a_pipe;
    logic [DATA_W-1:0] b_pipe;

    logic              wr_en;
    logic [WORD_W-1:0] wr_word;
    logic              wr_half;
    logic              wr_x9;
    logic [DATA_W-1:0] wr_data;
    logic              unused_addr_bits;

    assign busy = 1'b0;

    // Byte-lane address bits carry no meaning for this array.
    assign unused_addr_bits = ^{a_addr[2:0], b_addr[2:0], c_addr[2:0]};

    // Read formatting: blocked port reads zero, x9 returns the selected half zero-extended.
    function automatic logic [DATA_W-1:0] rd_format(input rd_ctx_t ctx, input logic [DATA_W-1:0] word);
        logic [DATA_W-1:0] res;
        res = word;
        if (ctx.blk != BLK_ON) begin
            res = '0;
        end else if (ctx.width == WIDTH_X9) begin
            res = {HALF_W'(0), ctx.half ? word[DATA_W-1:HALF_W] : word[HALF_W-1:0]};
        end
        return res;
    endfunction

    // Write-port decode; x9 merges the new half into the existing word.
    always_comb begin
        wr_en   = c_wen && (c_blk == BLK_ON);
        wr_word = c_addr[9:4];
        wr_half = c_addr[3];
        wr_x9   = (c_width == WIDTH_X9);
        wr_data = c_din;
        if (wr_x9) begin
            if (wr_half) begin
                wr_data = {c_din[HALF_W-1:0], mem[wr_word][HALF_W-1:0]};
            end else begin
                wr_data = {mem[wr_word][DATA_W-1:HALF_W], c_din[HALF_W-1:0]};
            end
        end
    end

`ifdef RAM64X18_RESET_ARRAY_EN
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else if (wr_en) begin
            mem[wr_word] <= wr_data;
        end
    end
`else
    always_ff @(posedge clock) begin
        if (wr_en) begin
            mem[wr_word] <= wr_data;
        end
    end
`endif

    // Per-port address/width/block capture.
    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            a_q <= '0;
            b_q <= '0;
        end else begin
            if (a_addr_en) begin
                a_q <= {a_addr[9:3], a_width, a_blk};
            end
            if (b_addr_en) begin
                b_q <= {b_addr[9:3], b_width, b_blk};
            end
        end
    end

    // Array is read asynchronously, so a same-edge write is seen only after that edge.
    assign a_flow = rd_format(a_q, mem[a_q.word]);
    assign b_flow = rd_format(b_q, mem[b_q.word]);

    always_ff @(posedge clock or negedge aresetn) begin
        if (!aresetn) begin
            a_pipe <= '0;
            b_pipe <= '0;
        end else begin
            if (a_dout_en) begin
                a_pipe <= a_flow;
            end
            if (b_dout_en) begin
                b_pipe <= b_flow;
            end
        end
    end

    assign a_dout = a_dout_lat ? a_flow : a_pipe;
    assign b_dout = b_dout_lat ? b_flow : b_pipe;

endmodule

// File: tb/tb_ram64x18.sv
// Directed self-checking bench for ram64x18; outputs sampled 1 time unit after the rising edge.
module tb_ram64x18;

    logic        clock = 1'b0;
    logic        aresetn;
    logic [9:0]  a_addr;
    logic [1:0]  a_blk;
    logic        a_addr_en;
    logic        a_dout_en;
    logic        a_dout_lat;
    logic [2:0]  a_width;
    logic [17:0] a_dout;
    logic [9:0]  b_addr;
    logic [1:0]  b_blk;
    logic        b_addr_en;
    logic        b_dout_en;
    logic        b_dout_lat;
    logic [2:0]  b_width;
    logic [17:0] b_dout;
    logic [9:0]  c_addr;
    logic [17:0] c_din;
    logic        c_wen;
    logic [1:0]  c_blk;
    logic [2:0]  c_width;
    logic        busy;

    int checks = 0;
    int errors = 0;

    ram64x18 dut (
        .clock      (clock),
        .aresetn    (aresetn),
        .a_addr     (a_addr),
        .a_blk      (a_blk),
        .a_addr_en  (a_addr_en),
        .a_dout_en  (a_dout_en),
        .a_dout_lat (a_dout_lat),
        .a_width    (a_width),
        .a_dout     (a_dout),
        .b_addr     (b_addr),
        .b_blk      (b_blk),
        .b_addr_en  (b_addr_en),
        .b_dout_en  (b_dout_en),
        .b_dout_lat (b_dout_lat),
        .b_width    (b_width),
        .b_dout     (b_dout),
        .c_addr     (c_addr),
        .c_din      (c_din),
        .c_wen      (c_wen),
        .c_blk      (c_blk),
        .c_width    (c_width),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic write(input logic [9:0] addr, input logic [17:0] din, input logic [2:0] width,
                         input logic [1:0] blk);
        c_addr  = addr;
        c_din   = din;
        c_width = width;
        c_blk   = blk;
        c_wen   = 1'b1;
        tick();
        c_wen   = 1'b0;
    endtask

    initial begin
        aresetn    = 1'b0;
        a_addr     = '0; a_blk = 2'b11; a_addr_en = 1'b0; a_dout_en = 1'b0;
        a_dout_lat = 1'b1; a_width = 3'b100;
        b_addr     = '0; b_blk = 2'b11; b_addr_en = 1'b0; b_dout_en = 1'b0;
        b_dout_lat = 1'b1; b_width = 3'b100;
        c_addr     = '0; c_din = '0; c_wen = 1'b0; c_blk = 2'b11; c_width = 3'b100;

        tick();
        check("reset_a", a_dout, 18'h0);
        check("reset_b", b_dout, 18'h0);
        check("busy", {17'd0, busy}, 18'h0);
        aresetn = 1'b1;
        tick();

        // x18 write then flow-through read on both ports
        write(10'h010, 18'h2A5A5, 3'b100, 2'b11);
        a_addr = 10'h010; a_addr_en = 1'b1;
        b_addr = 10'h010; b_addr_en = 1'b1;
        tick();
        a_addr_en = 1'b0; b_addr_en = 1'b0;
        check("x18_flow_a", a_dout, 18'h2A5A5);
        check("x18_flow_b_same", b_dout, 18'h2A5A5);

        // x9 halves of word 2: addr 40 -> upper half, addr 32 -> lower half
        write(10'd40, 18'h000AB, 3'b011, 2'b11);
        write(10'd32, 18'h3F0CD, 3'b011, 2'b11);
        a_addr = 10'd40; a_width = 3'b011; a_addr_en = 1'b1;
        b_addr = 10'd32; b_width = 3'b011; b_addr_en = 1'b1;
        tick();
        check("x9_read_hi", a_dout, 18'h000AB);
        check("x9_read_lo", b_dout, 18'h000CD);
        a_addr = 10'd32; a_width = 3'b100;
        b_addr = 10'd39; b_width = 3'b111;
        tick();
        a_addr_en = 1'b0; b_addr_en = 1'b0;
        check("x18_word2", a_dout, 18'h156CD);
        check("bad_width_as_x18", b_dout, 18'h156CD);

        // Pipelined: two-cycle latency, then hold with dout_en low
        a_addr = 10'h010; a_addr_en = 1'b1; a_dout_lat = 1'b0; a_dout_en = 1'b1;
        tick();
        a_addr_en = 1'b0;
        check("pipe_stage1_old", a_dout, 18'h156CD);
        tick();
        check("pipe_stage2_new", a_dout, 18'h2A5A5);
        a_dout_en = 1'b0; a_addr = 10'd32; a_addr_en = 1'b1;
        tick();
        a_addr_en = 1'b0;
        tick();
        check("pipe_hold", a_dout, 18'h2A5A5);
        a_dout_lat = 1'b1;
        #1;
        check("flow_after_hold", a_dout, 18'h156CD);

        // Read-during-write on word 5
        write(10'h050, 18'h00001, 3'b100, 2'b11);
        a_addr = 10'h050; a_addr_en = 1'b1;
        tick();
        a_addr_en = 1'b0;
        check("rdw_before", a_dout, 18'h00001);
        c_addr = 10'h050; c_din = 18'h3FFFF; c_width = 3'b100; c_blk = 2'b11; c_wen = 1'b1;
        #1;
        check("rdw_write_cycle_old", a_dout, 18'h00001);
        tick();
        c_wen = 1'b0;
        check("rdw_next_new", a_dout, 18'h3FFFF);

        // Write with wrong block select is ignored
        write(10'h050, 18'h00000, 3'b100, 2'b01);
        check("blk_write_ignored", a_dout, 18'h3FFFF);
        c_blk = 2'b11;

        // Read port with block select off returns zero
        b_addr = 10'h050; b_blk = 2'b10; b_width = 3'b100; b_addr_en = 1'b1;
        tick();
        check("blk_read_off", b_dout, 18'h0);
        b_blk = 2'b11; b_addr = 10'h010;
        tick();
        b_addr_en = 1'b0;
        check("blk_read_on", b_dout, 18'h2A5A5);

        // Asynchronous reset mid-read
        aresetn = 1'b0;
        #1;
        check("arst_a", a_dout, 18'h0);
        check("arst_b", b_dout, 18'h0);
        tick();
        aresetn = 1'b1;
        a_addr = 10'h050; a_blk = 2'b11; a_width = 3'b100; a_addr_en = 1'b1; a_dout_lat = 1'b1;
        tick();
        a_addr_en = 1'b0;
`ifdef RAM64X18_RESET_ARRAY_EN
        check("post_reset_array", a_dout, 18'h0);
`else
        check("post_reset_array", a_dout, 18'h3FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
